// File: rtl/mem_pkg.sv
// Shared constants and helpers for the memory responder models.
package mem_pkg;

  // Reset contents of instruction memory: addi x0, x0, 0.
  localparam logic [31:0] NOP_INST = 32'h00000013;

  // Feedback taps 16,14,13,11 expressed as state bit positions 15,13,12,10.
  localparam logic [15:0] LFSR16_TAPS = 16'hB400;

  // Deepest response pipeline the responders support.
  localparam int MAX_LATENCY = 8;

  // One Fibonacci step: shift left and feed the tap parity into bit 0.
  function automatic logic [15:0] lfsr16_next(input logic [15:0] state);
    return {state[14:0], ^(state & LFSR16_TAPS)};
  endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Instruction-fetch memory port: request (addr/ren/ready) and response (rdata/valid).
interface imem_responder_if;
  logic [31:0] mem_addr;
  logic        mem_ren;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        mem_valid;

  // Requester side (icache or testbench).
  modport master (
    output mem_addr,
    output mem_ren,
    input  mem_ready,
    input  mem_rdata,
    input  mem_valid
  );

  // Memory side (responder).
  modport slave (
    input  mem_addr,
    input  mem_ren,
    output mem_ready,
    output mem_rdata,
    output mem_valid
  );
endinterface

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR used to generate pseudo-random stall patterns.
module lfsr16
  import mem_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  output logic [15:0] o_state
);

  logic [15:0] state_q;
  logic [15:0] state_d;

  // Advance one step when enabled, otherwise hold.
  always_comb begin
    state_d = state_q;
    if (i_en) begin
      state_d = lfsr16_next(state_q);
    end
  end

  // State register; reset reloads the seed so stall patterns are repeatable.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign o_state = state_q;

endmodule

// File: rtl/imem_responder.sv
// Instruction memory responder: word array, fixed-latency in-order responses,
// outstanding-request limit and optional LFSR-driven request backpressure.
module imem_responder
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_WORDS_LOG2 = 12,
  parameter int unsigned LATENCY         = 2,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned STALL_RATE      = 0,
  parameter logic [15:0] STALL_SEED      = 16'hACE1,
  parameter logic [31:0] RESET_FILL      = NOP_INST
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  imem_responder_if.slave         mem,
  input  logic                    i_load_wen,
  input  logic [31:0]             i_load_addr,
  input  logic [31:0]             i_load_wdata,
  output logic [3:0]              o_outstanding
);

  localparam int unsigned DEPTH = 1 << ADDR_WORDS_LOG2;

  // Reject configurations the pipeline and counter cannot represent.
  if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_latency
    $error("imem_responder: LATENCY must be within 1..%0d", MAX_LATENCY);
  end
  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > LATENCY) begin : g_bad_outstanding
    $error("imem_responder: MAX_OUTSTANDING must be within 1..LATENCY");
  end
  if (STALL_RATE > 15) begin : g_bad_stall_rate
    $error("imem_responder: STALL_RATE must be within 0..15");
  end
  if (STALL_SEED == 16'h0000) begin : g_bad_seed
    $error("imem_responder: STALL_SEED must be non-zero");
  end
  if (ADDR_WORDS_LOG2 < 1 || ADDR_WORDS_LOG2 > 29) begin : g_bad_depth
    $error("imem_responder: ADDR_WORDS_LOG2 must be within 1..29");
  end

  // Backing store; contents come up as RESET_FILL and survive i_rst.
  logic [31:0] mem_array [DEPTH] = '{default: RESET_FILL};

  logic [ADDR_WORDS_LOG2-1:0] rd_idx;
  logic [ADDR_WORDS_LOG2-1:0] wr_idx;
  logic [15:0]                lfsr_state;
  logic                       stall;
  logic                       ready;
  logic                       accept;
  logic                       resp_valid;
  logic [31:0]                rd_data_q;
  logic [LATENCY-1:0]         valid_q;
  logic [LATENCY-1:0]         valid_d;
  logic [LATENCY-1:0][31:0]   stage_data;
  logic [3:0]                 cnt_q;
  logic [3:0]                 cnt_d;

  // Upper address bits wrap modulo the array size; byte offsets are ignored.
  assign rd_idx = mem.mem_addr[ADDR_WORDS_LOG2+1:2];
  assign wr_idx = i_load_addr[ADDR_WORDS_LOG2+1:2];

  // Free-running stall source; only the low nibble is compared.
  lfsr16 #(
    .SEED (STALL_SEED)
  ) u_lfsr (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (1'b1),
    .o_state (lfsr_state)
  );

  assign stall  = (STALL_RATE != 0) && (lfsr_state[3:0] < 4'(STALL_RATE));
  // Ready looks only at the registered count, so a response never reopens it in the same cycle.
  assign ready  = !i_rst && (cnt_q < 4'(MAX_OUTSTANDING)) && !stall;
  assign accept = mem.mem_ren && ready;

  // Block RAM: loader write port plus registered read; a same-cycle write returns old data.
  always_ff @(posedge i_clk) begin
    if (i_load_wen) begin
      mem_array[wr_idx] <= i_load_wdata;
    end
    if (i_rst) begin
      rd_data_q <= '0;
    end else if (accept) begin
      rd_data_q <= mem_array[rd_idx];
    end
  end

  // Valid bits shift one stage per cycle; stage 0 is the cycle after acceptance.
  always_comb begin
    valid_d    = '0;
    valid_d[0] = accept;
    for (int k = 1; k < int'(LATENCY); k++) begin
      valid_d[k] = valid_q[k-1];
    end
  end

  // Valid pipeline register; reset flushes every response still in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign stage_data[0] = rd_data_q;

  // Data stages load only behind a valid entry, so the output word holds between responses.
  for (genvar gi = 1; gi < int'(LATENCY); gi++) begin : g_stage
    logic [31:0] data_q;
    logic [31:0] data_d;

    // Take the word from the previous stage when it carries a response.
    always_comb begin
      data_d = data_q;
      if (valid_q[gi-1]) begin
        data_d = stage_data[gi-1];
      end
    end

    // Stage data register, cleared on reset.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        data_q <= '0;
      end else begin
        data_q <= data_d;
      end
    end

    assign stage_data[gi] = data_q;
  end

  assign resp_valid    = valid_q[LATENCY-1];
  assign mem.mem_valid = resp_valid;
  assign mem.mem_rdata = stage_data[LATENCY-1];
  assign mem.mem_ready = ready;

  // Outstanding count: up on accept, down on response, unchanged when both coincide.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({accept, resp_valid})
      2'b10:   cnt_d = cnt_q + 4'd1;
      2'b01:   cnt_d = cnt_q - 4'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Outstanding counter register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_outstanding = cnt_q;

  // Address bits above the array and below word alignment, and upper LFSR bits, are deliberately ignored.
  logic unused_bits;
  assign unused_bits = ^{mem.mem_addr[31:ADDR_WORDS_LOG2+2], mem.mem_addr[1:0],
                         i_load_addr[31:ADDR_WORDS_LOG2+2], i_load_addr[1:0],
                         lfsr_state[15:4]};

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: four instances cover the basic read path,
// full pipelining, the single-outstanding limit and stall injection.
module tb_imem_responder;

  logic        clk = 1'b0;
  logic        rst      [4];
  logic        ld_wen   [4];
  logic [31:0] ld_addr  [4];
  logic [31:0] ld_wdata [4];
  logic [3:0]  outs     [4];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  imem_responder_if if_a ();
  imem_responder_if if_b ();
  imem_responder_if if_c ();
  imem_responder_if if_d ();

  imem_responder #(.LATENCY(2), .MAX_OUTSTANDING(2)) dut_a (
    .i_clk(clk), .i_rst(rst[0]), .mem(if_a), .i_load_wen(ld_wen[0]),
    .i_load_addr(ld_addr[0]), .i_load_wdata(ld_wdata[0]), .o_outstanding(outs[0]));

  imem_responder #(.LATENCY(3), .MAX_OUTSTANDING(3)) dut_b (
    .i_clk(clk), .i_rst(rst[1]), .mem(if_b), .i_load_wen(ld_wen[1]),
    .i_load_addr(ld_addr[1]), .i_load_wdata(ld_wdata[1]), .o_outstanding(outs[1]));

  imem_responder #(.LATENCY(2), .MAX_OUTSTANDING(1)) dut_c (
    .i_clk(clk), .i_rst(rst[2]), .mem(if_c), .i_load_wen(ld_wen[2]),
    .i_load_addr(ld_addr[2]), .i_load_wdata(ld_wdata[2]), .o_outstanding(outs[2]));

  imem_responder #(.LATENCY(2), .MAX_OUTSTANDING(2), .STALL_RATE(8)) dut_d (
    .i_clk(clk), .i_rst(rst[3]), .mem(if_d), .i_load_wen(ld_wen[3]),
    .i_load_addr(ld_addr[3]), .i_load_wdata(ld_wdata[3]), .o_outstanding(outs[3]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic load(input int u, input logic [31:0] a, input logic [31:0] d);
    ld_wen[u]   = 1'b1;
    ld_addr[u]  = a;
    ld_wdata[u] = d;
    tick();
    ld_wen[u]   = 1'b0;
  endtask

  logic        exp_rdy   [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [3:0]  exp_outs  [7] = '{4'd0, 4'd1, 4'd1, 4'd0, 4'd1, 4'd1, 4'd0};
  logic        exp_vld   [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [31:0] exp_dat   [7] = '{32'h0, 32'h0, 32'hC0000000, 32'h0, 32'h0, 32'hC0000001, 32'h0};

  logic [31:0] dmem [64];
  logic [31:0] sb_q [$];
  logic [31:0] exp_word;
  logic [31:0] rnd;
  logic [31:0] rnd2;
  logic [5:0]  idx6;
  logic [15:0] lfsr_m;
  logic        stall_m;
  logic        ren_d;
  int          k_c;
  int          low_cnt;
  int          resp_cnt;
  int          acc_cnt;

  initial begin
    for (int i = 0; i < 4; i++) begin
      rst[i] = 1'b1; ld_wen[i] = 1'b0; ld_addr[i] = '0; ld_wdata[i] = '0;
    end
    if_a.mem_ren = 1'b0; if_a.mem_addr = '0;
    if_b.mem_ren = 1'b0; if_b.mem_addr = '0;
    if_c.mem_ren = 1'b0; if_c.mem_addr = '0;
    if_d.mem_ren = 1'b0; if_d.mem_addr = '0;
    tick();
    tick();

    // ---------------- instance A: LATENCY=2, MAX_OUTSTANDING=2 ----------------
    load(0, 32'h100, 32'hDEADBEEF);
    load(0, 32'h104, 32'h12345678);
    load(0, 32'h000, 32'h0000A5A5);
    chk("a_rst_ready", if_a.mem_ready, 0);
    chk("a_rst_valid", if_a.mem_valid, 0);
    chk("a_rst_rdata", if_a.mem_rdata, 0);
    chk("a_rst_outs", outs[0], 0);
    rst[0] = 1'b0;
    #1;
    chk("a_ready_after_rst", if_a.mem_ready, 1);
    if_a.mem_ren = 1'b1; if_a.mem_addr = 32'h100;
    tick();
    if_a.mem_addr = 32'h107;
    chk("a_c1_valid", if_a.mem_valid, 0);
    chk("a_c1_outs", outs[0], 1);
    chk("a_c1_ready", if_a.mem_ready, 1);
    tick();
    if_a.mem_ren = 1'b0;
    chk("a_c2_valid", if_a.mem_valid, 1);
    chk("a_c2_rdata", if_a.mem_rdata, 32'hDEADBEEF);
    chk("a_c2_outs", outs[0], 2);
    chk("a_c2_ready_full", if_a.mem_ready, 0);
    tick();
    chk("a_c3_valid", if_a.mem_valid, 1);
    chk("a_c3_rdata_lowbits", if_a.mem_rdata, 32'h12345678);
    chk("a_c3_outs", outs[0], 1);
    chk("a_c3_ready", if_a.mem_ready, 1);
    tick();
    chk("a_c4_valid", if_a.mem_valid, 0);
    chk("a_c4_outs", outs[0], 0);
    chk("a_c4_rdata_hold", if_a.mem_rdata, 32'h12345678);

    if_a.mem_ren = 1'b1; if_a.mem_addr = 32'h4000;
    tick();
    if_a.mem_ren = 1'b0;
    tick();
    chk("a_wrap_valid", if_a.mem_valid, 1);
    chk("a_wrap_rdata", if_a.mem_rdata, 32'h0000A5A5);
    tick();

    ld_wen[0] = 1'b1; ld_addr[0] = 32'h200; ld_wdata[0] = 32'hAAAA5555;
    if_a.mem_ren = 1'b1; if_a.mem_addr = 32'h200;
    tick();
    ld_wen[0] = 1'b0; if_a.mem_ren = 1'b0;
    tick();
    chk("a_rw_old_valid", if_a.mem_valid, 1);
    chk("a_rw_old_rdata", if_a.mem_rdata, 32'h00000013);
    tick();
    if_a.mem_ren = 1'b1; if_a.mem_addr = 32'h200;
    tick();
    if_a.mem_ren = 1'b0;
    tick();
    chk("a_rw_new_valid", if_a.mem_valid, 1);
    chk("a_rw_new_rdata", if_a.mem_rdata, 32'hAAAA5555);
    tick();

    if_a.mem_ren = 1'b1; if_a.mem_addr = 32'h0;
    tick();
    if_a.mem_addr = 32'h4;
    tick();
    if_a.mem_ren = 1'b0;
    rst[0] = 1'b1;
    #1;
    chk("a_mid_rst_ready", if_a.mem_ready, 0);
    chk("a_mid_rst_outs_pre", outs[0], 2);
    tick();
    chk("a_mid_rst_valid", if_a.mem_valid, 0);
    chk("a_mid_rst_outs", outs[0], 0);
    chk("a_mid_rst_rdata", if_a.mem_rdata, 0);
    chk("a_mid_rst_ready2", if_a.mem_ready, 0);
    tick();
    rst[0] = 1'b0;
    #1;
    chk("a_post_rst_ready", if_a.mem_ready, 1);
    tick();
    chk("a_post_rst_valid", if_a.mem_valid, 0);
    if_a.mem_ren = 1'b1; if_a.mem_addr = 32'h104;
    tick();
    if_a.mem_ren = 1'b0;
    tick();
    chk("a_intact_valid", if_a.mem_valid, 1);
    chk("a_intact_rdata", if_a.mem_rdata, 32'h12345678);
    tick();

    // ---------------- instance B: LATENCY=3, MAX_OUTSTANDING=3 ----------------
    for (int i = 0; i < 4; i++) load(1, 32'(i * 4), 32'hB0000000 + 32'(i));
    rst[1] = 1'b0;
    #1;
    if_b.mem_ren = 1'b1; if_b.mem_addr = 32'h0;
    chk("b_c0_ready", if_b.mem_ready, 1);
    chk("b_c0_outs", outs[1], 0);
    tick();
    if_b.mem_addr = 32'h4;
    chk("b_c1_ready", if_b.mem_ready, 1);
    chk("b_c1_outs", outs[1], 1);
    tick();
    if_b.mem_addr = 32'h8;
    chk("b_c2_ready", if_b.mem_ready, 1);
    chk("b_c2_outs", outs[1], 2);
    tick();
    if_b.mem_addr = 32'hC;
    chk("b_c3_ready_full", if_b.mem_ready, 0);
    chk("b_c3_outs_peak", outs[1], 3);
    chk("b_c3_valid", if_b.mem_valid, 1);
    chk("b_c3_rdata", if_b.mem_rdata, 32'hB0000000);
    tick();
    chk("b_c4_ready", if_b.mem_ready, 1);
    chk("b_c4_outs", outs[1], 2);
    chk("b_c4_valid", if_b.mem_valid, 1);
    chk("b_c4_rdata", if_b.mem_rdata, 32'hB0000001);
    tick();
    if_b.mem_ren = 1'b0;
    chk("b_c5_outs", outs[1], 2);
    chk("b_c5_valid", if_b.mem_valid, 1);
    chk("b_c5_rdata", if_b.mem_rdata, 32'hB0000002);
    tick();
    chk("b_c6_valid", if_b.mem_valid, 0);
    chk("b_c6_outs", outs[1], 1);
    tick();
    chk("b_c7_valid", if_b.mem_valid, 1);
    chk("b_c7_rdata", if_b.mem_rdata, 32'hB0000003);
    tick();
    chk("b_c8_valid", if_b.mem_valid, 0);
    chk("b_c8_outs", outs[1], 0);

    // ---------------- instance C: LATENCY=2, MAX_OUTSTANDING=1 ----------------
    for (int i = 0; i < 3; i++) load(2, 32'(i * 4), 32'hC0000000 + 32'(i));
    rst[2] = 1'b0;
    #1;
    k_c = 0;
    for (int t = 0; t < 7; t++) begin
      if_c.mem_ren  = 1'b1;
      if_c.mem_addr = 32'(k_c * 4);
      chk($sformatf("c_t%0d_ready", t), if_c.mem_ready, exp_rdy[t]);
      chk($sformatf("c_t%0d_outs", t), outs[2], exp_outs[t]);
      chk($sformatf("c_t%0d_valid", t), if_c.mem_valid, exp_vld[t]);
      if (exp_vld[t]) chk($sformatf("c_t%0d_rdata", t), if_c.mem_rdata, exp_dat[t]);
      if (if_c.mem_ready) k_c++;
      tick();
    end
    if_c.mem_ren = 1'b0;

    // ---------------- instance D: STALL_RATE=8 random traffic ----------------
    for (int i = 0; i < 64; i++) begin
      dmem[i] = 32'hD00D0000 | 32'(i);
      load(3, 32'(i * 4), dmem[i]);
    end
    rst[3] = 1'b0;
    #1;
    lfsr_m   = 16'hACE1;
    low_cnt  = 0;
    resp_cnt = 0;
    acc_cnt  = 0;
    for (int t = 0; t < 1010; t++) begin
      stall_m = (lfsr_m[3:0] < 4'd8);
      if (t < 1000 && !if_d.mem_ready) low_cnt++;
      chk("d_ready", if_d.mem_ready, (sb_q.size() < 2) && !stall_m);
      chk("d_outs", outs[3], sb_q.size());
      if (if_d.mem_valid) begin
        chk("d_pending", (sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
          exp_word = sb_q.pop_front();
          chk("d_rdata", if_d.mem_rdata, exp_word);
        end
        resp_cnt++;
      end
      rnd   = $urandom();
      rnd2  = $urandom();
      idx6  = 6'($urandom_range(0, 63));
      ren_d = (t < 1000) && (rnd[1:0] != 2'b00);
      if_d.mem_ren  = ren_d;
      if_d.mem_addr = {rnd2[31:14], 6'b000000, idx6, rnd2[1:0]};
      if (ren_d && if_d.mem_ready) begin
        sb_q.push_back(dmem[idx6]);
        acc_cnt++;
      end
      lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
      tick();
    end
    if_d.mem_ren = 1'b0;
    chk("d_all_answered", sb_q.size(), 0);
    chk("d_resp_count", resp_cnt, acc_cnt);
    chk("d_stall_ratio", (low_cnt >= 300 && low_cnt <= 800), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
